// File: rtl/scoreboard_reader_pkg.sv
// Shared definitions for the scoreboard reader: FSM states, button bit
// positions, the game-over encoding and the entry address helper.
package scoreboard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ_ID = 2'd1,
        ST_REQ_SC = 2'd2,
        ST_CAP_SC = 2'd3
    } state_e;

    localparam int NUM_BUTTONS = 3;
    localparam int BTN_NEXT    = 0;
    localparam int BTN_PREV    = 1;
    localparam int BTN_REFRESH = 2;

    localparam logic [1:0]  GAME_OVER = 2'b10;
    localparam logic [15:0] EMPTY_ID  = 16'hFFFF;

    // Word address of an entry's user_id; the score sits one word above.
    // The sum wraps naturally at 16 bits.
    function automatic logic [15:0] id_word_addr(input logic [15:0] base,
                                                 input logic [7:0]  idx);
        return base + {7'd0, idx, 1'b0};
    endfunction

endpackage

// File: rtl/scoreboard_reader_if.sv
// Read-only RAM port used by the scoreboard reader. The reader is the
// master (drives address/strobe); the memory model or RAM is the slave.
interface scoreboard_reader_if;
    logic [15:0] address;
    logic        rd_en;
    logic [15:0] ram_data;

    modport master (output address, output rd_en, input ram_data);
    modport slave  (input address, input rd_en, output ram_data);
endinterface

// File: rtl/scoreboard_reader_button_edge.sv
// Rising-edge detector for a bank of synchronous level buttons. An edge is
// reported for exactly one cycle: level high now, registered copy low.
module button_edge #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] level_r;

    // Keep last cycle's button levels as the edge reference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_r <= {WIDTH{1'b0}};
        end else begin
            level_r <= level;
        end
    end

    assign rise = level & ~level_r;

endmodule

// File: rtl/scoreboard_reader.sv
// Scoreboard reader: walks a table of {user_id, score} pairs stored in RAM
// under button control and presents the selected entry for display. Each
// fetch takes a fixed three-cycle read sequence; triggers seen while a fetch
// is in flight are dropped.
module scoreboard_reader
    import scoreboard_pkg::*;
#(
    parameter int          NUM_ENTRIES = 8,
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    localparam int         IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             buttons,
    input  logic [1:0]             game_state,
    scoreboard_reader_if.master    ram,
    output logic [31:0]            display_data,
    output logic                   display_valid,
    output logic [IDX_W-1:0]       entry_index,
    output logic                   entry_empty,
    output logic                   busy
);

    state_e           state_r;
    logic [2:0]       rise_s;
    logic [1:0]       game_state_r;
    logic [15:0]      user_id_r;
    logic             game_over_edge_s;
    logic             fetch_s;
    logic [IDX_W-1:0] target_idx_s;

    button_edge #(
        .WIDTH (NUM_BUTTONS)
    ) u_button_edge (
        .clk   (clk),
        .rst   (rst),
        .level (buttons),
        .rise  (rise_s)
    );

    // Remember the previous game state so entry into game-over is a single trigger.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            game_state_r <= 2'b00;
        end else begin
            game_state_r <= game_state;
        end
    end

    // Decide whether an idle reader should start a fetch and for which index.
    always_comb begin
        game_over_edge_s = (game_state == GAME_OVER) && (game_state_r != GAME_OVER);
        target_idx_s     = entry_index;
        fetch_s          = 1'b0;
        if (rise_s[BTN_NEXT] && !rise_s[BTN_PREV]) begin
            target_idx_s = entry_index + {{(IDX_W-1){1'b0}}, 1'b1};
            fetch_s      = 1'b1;
        end else if (rise_s[BTN_PREV] && !rise_s[BTN_NEXT]) begin
            target_idx_s = entry_index - {{(IDX_W-1){1'b0}}, 1'b1};
            fetch_s      = 1'b1;
        end else if (rise_s[BTN_REFRESH] || game_over_edge_s) begin
            target_idx_s = entry_index;
            fetch_s      = 1'b1;
        end else begin
            target_idx_s = entry_index;
            fetch_s      = 1'b0;
        end
    end

    // Fetch sequencer with all outputs registered; reset starts an entry-0 fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_REQ_ID;
            entry_index   <= {IDX_W{1'b0}};
            display_data  <= 32'h0000_0000;
            display_valid <= 1'b0;
            entry_empty   <= 1'b0;
            user_id_r     <= 16'h0000;
            busy          <= 1'b1;
            ram.rd_en     <= 1'b0;
            ram.address   <= BASE_ADDR;
        end else begin
            display_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (fetch_s) begin
                        entry_index <= target_idx_s;
                        ram.address <= id_word_addr(BASE_ADDR, 8'(target_idx_s));
                        ram.rd_en   <= 1'b1;
                        busy        <= 1'b1;
                        state_r     <= ST_REQ_ID;
                    end else begin
                        ram.rd_en   <= 1'b0;
                        busy        <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                ST_REQ_ID: begin
                    ram.address <= ram.address + 16'd1;
                    ram.rd_en   <= 1'b1;
                    state_r     <= ST_REQ_SC;
                end
                ST_REQ_SC: begin
                    user_id_r   <= ram.ram_data;
                    ram.rd_en   <= 1'b0;
                    state_r     <= ST_CAP_SC;
                end
                ST_CAP_SC: begin
                    display_data  <= {user_id_r, ram.ram_data};
                    entry_empty   <= (user_id_r == EMPTY_ID);
                    display_valid <= 1'b1;
                    busy          <= 1'b0;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    ram.rd_en <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scoreboard_reader.sv
// Directed bench for scoreboard_reader: synchronous RAM model with one-cycle
// read latency, hand-set table contents and per-step expected values.
module tb_scoreboard_reader;
    import scoreboard_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  buttons = 3'b000;
    logic [1:0]  game_state = 2'b01;
    logic [31:0] display_data;
    logic        display_valid;
    logic [2:0]  entry_index;
    logic        entry_empty;
    logic        busy;

    scoreboard_reader_if ram_bus ();

    scoreboard_reader #(
        .NUM_ENTRIES (8),
        .BASE_ADDR   (16'h0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .buttons       (buttons),
        .game_state    (game_state),
        .ram           (ram_bus),
        .display_data  (display_data),
        .display_valid (display_valid),
        .entry_index   (entry_index),
        .entry_empty   (entry_empty),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:15];
    int          n_checks = 0;
    int          n_fail = 0;
    int          valid_cnt = 0;
    int          rd_cnt = 0;
    logic [15:0] addr_log [$];

    // Synchronous RAM: data for the current address appears after one edge.
    always @(posedge clk) begin
        ram_bus.ram_data <= mem[ram_bus.address[3:0]];
    end

    // Count display pulses and log read addresses.
    always @(negedge clk) begin
        if (display_valid) valid_cnt <= valid_cnt + 1;
        if (ram_bus.rd_en) begin
            rd_cnt <= rd_cnt + 1;
            addr_log.push_back(ram_bus.address);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (display_valid) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic press(input int b, input int exp_idx, input string tag);
        int lat;
        buttons[b] = 1'b1;
        wait_valid(lat);
        buttons = 3'b000;
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_index"}, 32'(entry_index), 32'(exp_idx));
        check({tag, "_data"}, display_data, {mem[2*exp_idx], mem[2*exp_idx+1]});
        check({tag, "_empty"}, 32'(entry_empty), 32'(mem[2*exp_idx] == 16'hFFFF));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int vc;
        int rc;
        for (int i = 0; i < 8; i++) begin
            mem[2*i]   = 16'h0042 + 16'(i);
            mem[2*i+1] = 16'h0100 + 16'(i * 17);
        end
        mem[10] = 16'hFFFF;

        // Reset values.
        tick(); tick(); tick();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_index", 32'(entry_index), 32'd0);
        check("rst_data", display_data, 32'h0000_0000);
        check("rst_valid", 32'(display_valid), 32'd0);
        check("rst_empty", 32'(entry_empty), 32'd0);
        check("rst_rd_en", 32'(ram_bus.rd_en), 32'd0);
        check("rst_addr", 32'(ram_bus.address), 32'h0000);

        // Automatic fetch of entry 0 after release.
        rst = 1'b0;
        tick();
        check("boot_e1_addr", 32'(ram_bus.address), 32'h0001);
        check("boot_e1_rd_en", 32'(ram_bus.rd_en), 32'd1);
        check("boot_e1_valid", 32'(display_valid), 32'd0);
        tick();
        check("boot_e2_rd_en", 32'(ram_bus.rd_en), 32'd0);
        check("boot_e2_valid", 32'(display_valid), 32'd0);
        tick();
        check("boot_e3_valid", 32'(display_valid), 32'd1);
        check("boot_e3_data", display_data, 32'h0042_0100);
        check("boot_e3_busy", 32'(busy), 32'd0);
        tick();
        check("boot_e4_valid", 32'(display_valid), 32'd0);
        check("boot_e4_rd_en", 32'(ram_bus.rd_en), 32'd0);

        // Next through the whole table, wrapping to 0.
        for (int k = 1; k <= 8; k++) press(BTN_NEXT, k % 8, "next");

        // Prev from 0 wraps to the last entry.
        addr_log.delete();
        press(BTN_PREV, 7, "prev_wrap");
        check("prev_addr_count", 32'(addr_log.size()), 32'd2);
        if (addr_log.size() == 2) begin
            check("prev_addr0", 32'(addr_log[0]), 32'h000E);
            check("prev_addr1", 32'(addr_log[1]), 32'h000F);
        end

        // Simultaneous next and prev: nothing happens.
        rc = rd_cnt;
        vc = valid_cnt;
        buttons = 3'b011;
        repeat (6) tick();
        buttons = 3'b000;
        tick();
        check("both_rd_cnt", 32'(rd_cnt - rc), 32'd0);
        check("both_valid_cnt", 32'(valid_cnt - vc), 32'd0);
        check("both_index", 32'(entry_index), 32'd7);

        // A second next edge while busy is dropped.
        vc = valid_cnt;
        buttons[BTN_NEXT] = 1'b1; tick();
        buttons[BTN_NEXT] = 1'b0; tick();
        buttons[BTN_NEXT] = 1'b1; tick();
        buttons[BTN_NEXT] = 1'b0;
        repeat (8) tick();
        check("busy_drop_valid_cnt", 32'(valid_cnt - vc), 32'd1);
        check("busy_drop_index", 32'(entry_index), 32'd0);
        check("busy_drop_data", display_data, 32'h0042_0100);

        // Refresh re-reads the current entry after the RAM changed.
        mem[1] = 16'h0999;
        press(BTN_REFRESH, 0, "refresh");
        check("refresh_value", display_data, 32'h0042_0999);

        // Game over at index 3 re-reads the updated score once.
        press(BTN_NEXT, 1, "to3a");
        press(BTN_NEXT, 2, "to3b");
        press(BTN_NEXT, 3, "to3c");
        mem[7] = 16'h0200;
        vc = valid_cnt;
        game_state = GAME_OVER;
        wait_valid(lat);
        check("go_latency", 32'(lat), 32'd4);
        check("go_data", display_data, 32'h0045_0200);
        repeat (6) tick();
        check("go_single_pulse", 32'(valid_cnt - vc), 32'd1);
        game_state = 2'b01;
        tick();

        // Reset during REQ_SC aborts the fetch.
        buttons[BTN_NEXT] = 1'b1;
        tick();
        tick();
        buttons = 3'b000;
        vc = valid_cnt;
        rst = 1'b1;
        #1;
        check("abort_valid", 32'(display_valid), 32'd0);
        check("abort_data", display_data, 32'h0000_0000);
        check("abort_index", 32'(entry_index), 32'd0);
        check("abort_rd_en", 32'(ram_bus.rd_en), 32'd0);
        check("abort_addr", 32'(ram_bus.address), 32'h0000);
        check("abort_empty", 32'(entry_empty), 32'd0);
        tick();
        tick();
        check("abort_no_pulse", 32'(valid_cnt - vc), 32'd0);
        rst = 1'b0;
        wait_valid(lat);
        check("abort_refetch_latency", 32'(lat), 32'd3);
        check("abort_refetch_data", display_data, 32'h0042_0999);
        check("abort_refetch_index", 32'(entry_index), 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scoreboard_reader.md
SCOREBOARD_READER -- requirements
Module: scoreboard_reader

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 8: number of scoreboard entries held in RAM (power of two, 2..256).
REQ-002 SHALL have parameter BASE_ADDR, default 16'h0000: RAM word address of entry 0.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port buttons  input  3  level buttons, synchronous to clk: [0]=next, [1]=prev, [2]=refresh.
REQ-007 SHALL have port game_state  input  2  game state; 2'b10 = game over.
REQ-008 SHALL have port address  output  16  RAM read address.
REQ-009 SHALL have port rd_en  output  1  RAM read strobe.
REQ-010 SHALL have port ram_data  input  16  RAM read data, valid one cycle after address/rd_en.
REQ-011 SHALL have port display_data  output  32  {user_id[31:16], score[15:0]} of the current entry.
REQ-012 SHALL have port display_valid  output  1  one-cycle pulse when display_data updates.
REQ-013 SHALL have port entry_index  output  $clog2(NUM_ENTRIES)  index of the displayed entry.
REQ-014 SHALL have port entry_empty  output  1  high when the displayed entry's user_id is 16'hFFFF.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL store entry i as user_id at BASE_ADDR+2i and score at BASE_ADDR+2i+1, with 16-bit wrap-around.
REQ-017 SHALL rising-edge detect each button with a registered copy; an edge is one cycle with the level 1 and the previous level 0.
REQ-018 SHALL act on edges only in IDLE; edges arriving while busy SHALL be discarded, not queued.
REQ-019 SHALL, on a next edge alone, set index to (index+1) mod NUM_ENTRIES and start a fetch.
REQ-020 SHALL, on a prev edge alone, set index to (index-1) mod NUM_ENTRIES and start a fetch; prev from 0 goes to NUM_ENTRIES-1.
REQ-021 SHALL ignore simultaneous next and prev edges, with no move and no fetch.
REQ-022 SHALL, on a refresh edge or a game_state transition into 2'b10, re-fetch the current index; next/prev take priority, and one fetch results when two triggers coincide.
REQ-023 SHALL implement the states IDLE -> REQ_ID -> REQ_SC -> CAP_SC -> IDLE, one cycle each.
REQ-024 SHALL, in REQ_ID, drive address to the id word with rd_en=1.
REQ-025 SHALL, in REQ_SC, drive address to the score word with rd_en=1 and capture ram_data as user_id.
REQ-026 SHALL, in CAP_SC, capture ram_data as score; display_data, entry_empty and display_valid=1 SHALL register on the edge leaving CAP_SC.
REQ-027 SHALL have latency such that an edge sampled at clock N gives display_valid high in the cycle after edge N+3.
REQ-028 SHALL hold rd_en=0 and address at its last value in IDLE.
REQ-029 SHALL never write RAM; this block is read-only.

Reset
REQ-030 SHALL, while rst is high, reset state to REQ_ID, entry_index to 0, display_data to 0, display_valid to 0, entry_empty to 0, rd_en to 0, address to BASE_ADDR and button history to 0.
REQ-031 SHALL, after rst release, automatically fetch entry 0, with the first display_valid in the cycle after the 3rd rising edge.
REQ-032 SHALL abort any in-flight fetch on rst mid-operation, with no partial display update.

Structure
REQ-033 SHALL keep state encodings, button bit indices and GAME_OVER=2'b10 in shared package scoreboard_pkg.
REQ-034 SHALL instantiate one sub-module, button_edge (3-bit rising-edge detector), in this block.

Verification
REQ-035 SHALL verify: RAM preloaded id[0]=16'h0042, score[0]=16'h0100, then reset released -> display_data=32'h00420100 and display_valid pulses at edge 3.
REQ-036 SHALL verify: next pressed 8 times with NUM_ENTRIES=8 -> entry_index 1..7 then 0, each display matching RAM.
REQ-037 SHALL verify: prev at index 0 -> entry_index=7 and address sequence 16'h000E, 16'h000F.
REQ-038 SHALL verify: next and prev rising in the same cycle -> no rd_en, index unchanged; next pressed while busy -> ignored.
REQ-039 SHALL verify: score[3] changed to 16'h0200, then game_state 01->10 at index 3 -> display_data updated to new score, one display_valid pulse.
REQ-040 SHALL verify: rst asserted during REQ_SC -> no display_valid, outputs at reset values, and a fresh entry 0 fetch follows release.
